dadda_mult_pipe: RTL

DADDA_MULT_PIPE -- requirements
Module: dadda_mult_pipe

---
 rtl/dadda_pkg.sv | 19 +
 rtl/dadda_tree.sv | 94 +++++++++
 rtl/dadda_mult_pipe.sv | 63 ++++++
 3 files changed

// File: rtl/dadda_pkg.sv
// dadda_pkg: Dadda height sequence, pipeline depth and result-width helpers shared by the multiplier.
package dadda_pkg;
  localparam int PIPE_STAGES = 3;
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int i = 1; i < j; i++) d = d * 3 / 2;
    return d;
  endfunction
  function automatic int dadda_stages(input int h);
    int n;
    n = 0;
    for (int j = 1; j < 16; j++) if (dadda_height(j) < h) n = j;
    return n;
  endfunction
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/dadda_tree.sv
// dadda_tree: partial products and Dadda column reduction down to two rows.
// Signed (Baugh-Wooley) support only when DADDA_MULT_PIPE_SIGNED_EN is defined.
module dadda_tree
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic                     sgn,
  output logic [prod_w(WIDTH)-1:0] row0,
  output logic [prod_w(WIDTH)-1:0] row1
);
  localparam int PW  = prod_w(WIDTH);
  localparam int H   = WIDTH + 1;
  localparam int NST = dadda_stages(WIDTH);
`ifndef DADDA_MULT_PIPE_SIGNED_EN
  logic unused_sgn;
  assign unused_sgn = sgn;
`endif
  always_comb begin
    logic [H-1:0] col [PW];
    logic [H-1:0] nxt [PW];
    int cnt [PW];
    int ncnt [PW];
    int k;
    int d;
    for (int c = 0; c < PW; c++) begin
      col[c] = '0;
      cnt[c] = 0;
      nxt[c] = '0;
      ncnt[c] = 0;
    end
    k = 0;
    d = 0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
`ifdef DADDA_MULT_PIPE_SIGNED_EN
        col[i+j][cnt[i+j]] = (a[j] & b[i]) ^ (sgn & ((i == WIDTH-1) != (j == WIDTH-1)));
`else
        col[i+j][cnt[i+j]] = a[j] & b[i];
`endif
        cnt[i+j]++;
      end
`ifdef DADDA_MULT_PIPE_SIGNED_EN
    // Baugh-Wooley correction: +2^WIDTH and +2^(2*WIDTH-1) in signed mode
    col[WIDTH][cnt[WIDTH]] = sgn;
    cnt[WIDTH]++;
    col[PW-1][cnt[PW-1]] = sgn;
    cnt[PW-1]++;
`endif
    for (int s = NST; s >= 1; s--) begin
      d = dadda_height(s);
      for (int c = 0; c < PW; c++) begin
        nxt[c] = '0;
        ncnt[c] = 0;
      end
      // carries land in nxt[c+1] before column c+1 is visited, so its height already counts them
      for (int c = 0; c < PW; c++) begin
        k = 0;
        for (int r = 0; r < H; r++)
          if (cnt[c] - k + ncnt[c] > d && cnt[c] - k >= 2) begin
            if (cnt[c] - k + ncnt[c] - d >= 2 && cnt[c] - k >= 3) begin
              nxt[c][ncnt[c]] = col[c][k] ^ col[c][k+1] ^ col[c][k+2];
              if (c < PW - 1) begin
                nxt[c+1][ncnt[c+1]] = (col[c][k] & col[c][k+1]) | (col[c][k+2] & (col[c][k] ^ col[c][k+1]));
                ncnt[c+1]++;
              end
              k += 3;
            end else begin
              nxt[c][ncnt[c]] = col[c][k] ^ col[c][k+1];
              if (c < PW - 1) begin
                nxt[c+1][ncnt[c+1]] = col[c][k] & col[c][k+1];
                ncnt[c+1]++;
              end
              k += 2;
            end
            ncnt[c]++;
          end
        for (int r = 0; r < H; r++)
          if (r >= k && r < cnt[c]) begin
            nxt[c][ncnt[c]] = col[c][r];
            ncnt[c]++;
          end
      end
      col = nxt;
      cnt = ncnt;
    end
    for (int c = 0; c < PW; c++) begin
      row0[c] = col[c][0];
      row1[c] = col[c][1];
    end
  end
endmodule

// File: rtl/dadda_mult_pipe.sv
// dadda_mult_pipe: 3-stage valid/ready pipelined Dadda multiplier with sideband tag.
// Signed operation is enabled by defining DADDA_MULT_PIPE_SIGNED_EN.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_signed,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [prod_w(WIDTH)-1:0] out_y,
  output logic [TAG_W-1:0]         out_tag
);
  localparam int PW = prod_w(WIDTH);
  logic             v1, v2, ld1, ld2, ld3, sgn1;
  logic [WIDTH-1:0] a1, b1;
  logic [TAG_W-1:0] tag1, tag2;
  logic [PW-1:0]    t0, t1, r0, r1;
  assign ld3 = !out_valid || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1;
  dadda_tree #(.WIDTH(WIDTH)) u_tree (.a(a1), .b(b1), .sgn(sgn1), .row0(t0), .row1(t1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      out_y <= '0;
      out_tag <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) out_valid <= v2;
      if (ld3 && v2) begin
        out_y <= r0 + r1;
        out_tag <= tag2;
      end
    end
  end
  // operand datapath is deliberately unreset; valid bits qualify it
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      a1 <= in_a;
      b1 <= in_b;
      sgn1 <= in_signed;
      tag1 <= in_tag;
    end
    if (ld2 && v1) begin
      r0 <= t0;
      r1 <= t1;
      tag2 <= tag1;
    end
  end
endmodule
